// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the ALU sharing arbiter and its callers.
package alu_ctrl_pkg;

  localparam int NUM_REQ  = 2;
  localparam int REQ_ID_W = 1;

  typedef enum logic [1:0] {
    ADDER = 2'b00,
    LOGIC = 2'b01,
    SHIFT = 2'b10,
    COMP  = 2'b11
  } mux2_sel_e;

  typedef enum logic {
    OPD12 = 1'b0,
    OPD34 = 1'b1
  } mux1_sel_e;

  typedef struct packed {
    mux1_sel_e  mux1;
    mux2_sel_e  mux2;
    logic [2:0] op;
  } alu_ctrl_t;

  function automatic logic [NUM_REQ-1:0] id2onehot(input logic [REQ_ID_W-1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; pointer remembers the last granted requester.
module rr_arbiter_2
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic r_last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to "last = 1" so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_last <= 1'b1;
    else if (advance) r_last <= gnt[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin accept,
// issue register driving the ALU, result register with per-owner response.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int OPERAND_LENGTH = 32,
  parameter int NUM_REQ        = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic [2*OPERAND_LENGTH-1:0] req_opd1,
  input  logic [2*OPERAND_LENGTH-1:0] req_opd2,
  input  logic [2*OPERAND_LENGTH-1:0] req_opd3,
  input  logic [2*OPERAND_LENGTH-1:0] req_opd4,
  input  logic [1:0]                  req_mux1_sel,
  input  logic [3:0]                  req_mux2_sel,
  input  logic [5:0]                  req_op_sel,
  output logic [OPERAND_LENGTH-1:0]   alu_opd1,
  output logic [OPERAND_LENGTH-1:0]   alu_opd2,
  output logic [OPERAND_LENGTH-1:0]   alu_opd3,
  output logic [OPERAND_LENGTH-1:0]   alu_opd4,
  output logic                        alu_mux1_select,
  output logic [1:0]                  alu_mux2_select,
  output logic [2:0]                  alu_op_select,
  input  logic [OPERAND_LENGTH-1:0]   alu_result,
  input  logic [OPERAND_LENGTH-1:0]   comp_result,
  output logic [1:0]                  resp_valid,
  input  logic [1:0]                  resp_ready,
  output logic [OPERAND_LENGTH-1:0]   resp_result,
  output logic [OPERAND_LENGTH-1:0]   resp_comp,
  output logic                        busy
);

  localparam int OL = OPERAND_LENGTH;

  if (NUM_REQ != 2) begin : g_bad_num_req
    $error("alu_arbiter supports exactly two requesters");
  end

  logic                r_iss_valid;
  logic [REQ_ID_W-1:0] r_iss_id;
  logic [OL-1:0]       r_iss_opd1, r_iss_opd2, r_iss_opd3, r_iss_opd4;
  alu_ctrl_t           r_iss_ctrl;

  logic                r_res_valid;
  logic [REQ_ID_W-1:0] r_res_id;
  logic [OL-1:0]       r_res_result, r_res_comp;

  logic [1:0]          w_gnt;
  logic                w_gnt_id;
  logic                w_accept;
  logic                w_res_pop, w_res_free, w_iss_move, w_iss_free;
  logic [OL-1:0]       w_sel_opd1, w_sel_opd2, w_sel_opd3, w_sel_opd4;
  logic                w_sel_mux1;
  logic [1:0]          w_sel_mux2;
  logic [2:0]          w_sel_op;

  // Two-stage elastic pipeline: everything may advance in the same cycle.
  assign w_res_pop  = r_res_valid & resp_ready[r_res_id];
  assign w_res_free = ~r_res_valid | w_res_pop;
  assign w_iss_move = r_iss_valid & w_res_free;
  assign w_iss_free = ~r_iss_valid | w_iss_move;

  rr_arbiter_2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (w_accept),
    .gnt     (w_gnt)
  );

  // Ready is forced low while reset is held so nothing is taken mid-reset.
  assign req_ready = (rst | ~w_iss_free) ? 2'b00 : w_gnt;
  assign w_accept  = |(req_valid & req_ready);
  assign w_gnt_id  = w_gnt[1];

  assign w_sel_opd1 = w_gnt_id ? req_opd1[2*OL-1:OL] : req_opd1[OL-1:0];
  assign w_sel_opd2 = w_gnt_id ? req_opd2[2*OL-1:OL] : req_opd2[OL-1:0];
  assign w_sel_opd3 = w_gnt_id ? req_opd3[2*OL-1:OL] : req_opd3[OL-1:0];
  assign w_sel_opd4 = w_gnt_id ? req_opd4[2*OL-1:OL] : req_opd4[OL-1:0];
  assign w_sel_mux1 = w_gnt_id ? req_mux1_sel[1]    : req_mux1_sel[0];
  assign w_sel_mux2 = w_gnt_id ? req_mux2_sel[3:2]  : req_mux2_sel[1:0];
  assign w_sel_op   = w_gnt_id ? req_op_sel[5:3]    : req_op_sel[2:0];

  // Issue register: fields only load on accept so the ALU inputs hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_valid <= 1'b0;
      r_iss_id    <= '0;
      r_iss_opd1  <= '0;
      r_iss_opd2  <= '0;
      r_iss_opd3  <= '0;
      r_iss_opd4  <= '0;
      r_iss_ctrl  <= '0;
    end else if (w_accept) begin
      r_iss_valid     <= 1'b1;
      r_iss_id        <= w_gnt_id;
      r_iss_opd1      <= w_sel_opd1;
      r_iss_opd2      <= w_sel_opd2;
      r_iss_opd3      <= w_sel_opd3;
      r_iss_opd4      <= w_sel_opd4;
      r_iss_ctrl.mux1 <= mux1_sel_e'(w_sel_mux1);
      r_iss_ctrl.mux2 <= mux2_sel_e'(w_sel_mux2);
      r_iss_ctrl.op   <= w_sel_op;
    end else if (w_iss_move) begin
      r_iss_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid  <= 1'b0;
      r_res_id     <= '0;
      r_res_result <= '0;
      r_res_comp   <= '0;
    end else if (w_iss_move) begin
      r_res_valid  <= 1'b1;
      r_res_id     <= r_iss_id;
      r_res_result <= alu_result;
      r_res_comp   <= comp_result;
    end else if (w_res_pop) begin
      r_res_valid <= 1'b0;
    end
  end

  assign alu_opd1        = r_iss_opd1;
  assign alu_opd2        = r_iss_opd2;
  assign alu_opd3        = r_iss_opd3;
  assign alu_opd4        = r_iss_opd4;
  assign alu_mux1_select = r_iss_ctrl.mux1;
  assign alu_mux2_select = r_iss_ctrl.mux2;
  assign alu_op_select   = r_iss_ctrl.op;

  assign resp_valid  = r_res_valid ? id2onehot(r_res_id) : 2'b00;
  assign resp_result = r_res_result;
  assign resp_comp   = r_res_comp;
  assign busy        = r_iss_valid | r_res_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stand-in ALU, queue-based reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_alu_arbiter;
  import alu_ctrl_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     req_valid = '0, req_ready;
  logic [2*W-1:0] req_opd1 = '0, req_opd2 = '0, req_opd3 = '0, req_opd4 = '0;
  logic [1:0]     req_mux1_sel = '0;
  logic [3:0]     req_mux2_sel = '0;
  logic [5:0]     req_op_sel = '0;
  logic [W-1:0]   alu_opd1, alu_opd2, alu_opd3, alu_opd4;
  logic           alu_mux1_select;
  logic [1:0]     alu_mux2_select;
  logic [2:0]     alu_op_select;
  logic [W-1:0]   alu_result, comp_result;
  logic [1:0]     resp_valid;
  logic [1:0]     resp_ready = '0;
  logic [W-1:0]   resp_result, resp_comp;
  logic           busy;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.OPERAND_LENGTH(W), .NUM_REQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opd1(req_opd1), .req_opd2(req_opd2), .req_opd3(req_opd3), .req_opd4(req_opd4),
    .req_mux1_sel(req_mux1_sel), .req_mux2_sel(req_mux2_sel), .req_op_sel(req_op_sel),
    .alu_opd1(alu_opd1), .alu_opd2(alu_opd2), .alu_opd3(alu_opd3), .alu_opd4(alu_opd4),
    .alu_mux1_select(alu_mux1_select), .alu_mux2_select(alu_mux2_select),
    .alu_op_select(alu_op_select),
    .alu_result(alu_result), .comp_result(comp_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_comp(resp_comp), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: {result, comp}.
  function automatic logic [2*W-1:0] alu_fn(input logic m1, input logic [1:0] m2,
      input logic [2:0] op, input logic [W-1:0] a, b, c, d);
    logic [W-1:0] x, y, r, cmp;
    x = m1 ? c : a;
    y = m1 ? d : b;
    case (m2)
      2'b00:   r = op[0] ? x - y : x + y;
      2'b01:   case (op[1:0])
                 2'b00:   r = x & y;
                 2'b01:   r = x | y;
                 2'b10:   r = x ^ y;
                 default: r = ~x;
               endcase
      2'b10:   r = op[0] ? x >> y[4:0] : x << y[4:0];
      default: r = {31'b0, x < y};
    endcase
    cmp = {29'b0, x < y, x == y, $signed(x) < $signed(y)};
    return {r, cmp};
  endfunction

  assign {alu_result, comp_result} = alu_fn(alu_mux1_select, alu_mux2_select, alu_op_select,
                                            alu_opd1, alu_opd2, alu_opd3, alu_opd4);

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic         id;
    logic         m1;
    logic [1:0]   m2;
    logic [2:0]   op;
    logic [W-1:0] a, b, c, d;
    logic [W-1:0] res, cmp;
  } op_t;

  op_t          q[$];        // in flight, oldest first
  bit           has_res;     // q[0] is sitting in the result stage
  op_t          shown_iss;   // last op presented to the ALU
  logic [W-1:0] shown_res, shown_cmp;
  bit           last1;

  function automatic op_t make_op(input int i);
    op_t o;
    logic [2*W-1:0] rc;
    o.id = 1'(i);
    o.m1 = req_mux1_sel[i];
    o.m2 = req_mux2_sel[2*i +: 2];
    o.op = req_op_sel[3*i +: 3];
    o.a  = req_opd1[W*i +: W];
    o.b  = req_opd2[W*i +: W];
    o.c  = req_opd3[W*i +: W];
    o.d  = req_opd4[W*i +: W];
    rc   = alu_fn(o.m1, o.m2, o.op, o.a, o.b, o.c, o.d);
    o.res = rc[2*W-1:W];
    o.cmp = rc[W-1:0];
    return o;
  endfunction

  function automatic op_t zero_op();
    op_t o;
    o.id = 0; o.m1 = 0; o.m2 = 0; o.op = 0;
    o.a = 0; o.b = 0; o.c = 0; o.d = 0; o.res = 0; o.cmp = 0;
    return o;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", {30'b0, req_ready}, 0);
      chk("rst_resp_valid", {30'b0, resp_valid}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_alu_opd1", alu_opd1, 0);
      chk("rst_alu_ctrl", {26'b0, alu_mux1_select, alu_mux2_select, alu_op_select}, 0);
      chk("rst_resp_result", resp_result, 0);
      q.delete();
      has_res   = 0;
      shown_iss = zero_op();
      shown_res = 0;
      shown_cmp = 0;
      last1     = 1;
    end else begin
      logic [1:0] g, e_ready, e_rv;
      bit iss_present, pop, res_free;
      op_t iss_e, nw;
      iss_present = q.size() > (has_res ? 1 : 0);
      iss_e       = iss_present ? q[has_res ? 1 : 0] : shown_iss;
      e_rv        = has_res ? (2'b01 << q[0].id) : 2'b00;
      pop         = has_res && resp_ready[q[0].id];
      res_free    = !has_res || pop;
      if (req_valid == 2'b11) g = last1 ? 2'b01 : 2'b10;
      else                    g = req_valid;
      e_ready = (!iss_present || res_free) ? g : 2'b00;

      chk("m_req_ready", {30'b0, req_ready}, {30'b0, e_ready});
      chk("m_resp_valid", {30'b0, resp_valid}, {30'b0, e_rv});
      chk("m_busy", {31'b0, busy}, {31'b0, q.size() > 0});
      chk("m_resp_result", resp_result, has_res ? q[0].res : shown_res);
      chk("m_resp_comp", resp_comp, has_res ? q[0].cmp : shown_cmp);
      chk("m_alu_opd1", alu_opd1, iss_e.a);
      chk("m_alu_opd2", alu_opd2, iss_e.b);
      chk("m_alu_opd3", alu_opd3, iss_e.c);
      chk("m_alu_opd4", alu_opd4, iss_e.d);
      chk("m_alu_ctrl", {26'b0, alu_mux1_select, alu_mux2_select, alu_op_select},
          {26'b0, iss_e.m1, iss_e.m2, iss_e.op});

      // advance the model by the coming clock edge
      if (pop) begin
        void'(q.pop_front());
        has_res = 0;
      end
      if (iss_present && res_free) begin
        has_res   = 1;
        shown_res = q[0].res;
        shown_cmp = q[0].cmp;
      end
      if (|(req_valid & e_ready)) begin
        nw = make_op(e_ready[1] ? 1 : 0);
        q.push_back(nw);
        shown_iss = nw;
        last1     = e_ready[1];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic m1, input logic [1:0] m2, input logic [2:0] op,
                         input logic [W-1:0] a, b, c, d);
    req_mux1_sel[i]       = m1;
    req_mux2_sel[2*i +: 2] = m2;
    req_op_sel[3*i +: 3]  = op;
    req_opd1[W*i +: W]    = a;
    req_opd2[W*i +: W]    = b;
    req_opd3[W*i +: W]    = c;
    req_opd4[W*i +: W]    = d;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tick();

    // single op: 5 + 3 from requester 0
    resp_ready = 2'b11;
    set_req(0, OPD12, ADDER, 3'b000, 5, 3, 0, 0);
    req_valid = 2'b01;
    #1 chk("single_ready", {30'b0, req_ready}, 2'b01);
    tick(); req_valid = 2'b00;
    #1 chk("single_alu_opd1", alu_opd1, 5);
    tick();
    #1 chk("single_resp_valid", {30'b0, resp_valid}, 2'b01);
    chk("single_resp_result", resp_result, 8);
    tick();

    // operand select from requester 1, then back-to-back (work-conserving)
    set_req(1, OPD34, COMP, 3'b000, 0, 0, 7, 9);
    req_valid = 2'b10;
    #1 chk("opsel_ready", {30'b0, req_ready}, 2'b10);
    tick();
    #1 chk("opsel_alu_mux1", {31'b0, alu_mux1_select}, 1);
    chk("opsel_alu_opd3", alu_opd3, 7);
    chk("opsel_alu_opd4", alu_opd4, 9);
    chk("wc_ready", {30'b0, req_ready}, 2'b10);
    tick(); req_valid = 2'b00;
    #1 chk("opsel_resp_valid", {30'b0, resp_valid}, 2'b10);
    chk("opsel_resp_comp", resp_comp, 5);
    chk("opsel_resp_result", resp_result, 1);
    tick(); tick();

    // contention: both valid for 4 cycles, pointer says requester 0 first
    set_req(0, OPD12, ADDER, 3'b001, 10, 4, 0, 0);
    set_req(1, OPD12, ADDER, 3'b000, 20, 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 4) ? 2'b11 : 2'b00;
      #1;
      if (k < 4) chk("cont_ready", {30'b0, req_ready}, (k % 2) ? 2'b10 : 2'b01);
      if (k >= 2) begin
        chk("cont_resp_valid", {30'b0, resp_valid}, (k % 2) ? 2'b10 : 2'b01);
        chk("cont_resp_result", resp_result, (k % 2) ? 21 : 6);
      end
      tick();
    end
    tick();

    // backpressure: owner not ready, req0 streams three ops
    resp_ready = 2'b00;
    set_req(0, OPD12, ADDER, 3'b000, 1, 0, 0, 0);
    req_valid = 2'b01;
    #1 chk("bp_ready0", {30'b0, req_ready}, 2'b01);
    tick(); set_req(0, OPD12, ADDER, 3'b000, 2, 0, 0, 0);
    #1 chk("bp_ready1", {30'b0, req_ready}, 2'b01);
    tick(); set_req(0, OPD12, ADDER, 3'b000, 3, 0, 0, 0);
    #1 chk("bp_ready2", {30'b0, req_ready}, 2'b00);
    chk("bp_alu_hold", alu_opd1, 2);
    tick();
    #1 chk("bp_ready_hold", {30'b0, req_ready}, 2'b00);
    chk("bp_alu_hold2", alu_opd1, 2);
    chk("bp_resp_valid", {30'b0, resp_valid}, 2'b01);
    tick(); resp_ready = 2'b01;
    #1 chk("bp_release_ready", {30'b0, req_ready}, 2'b01);
    chk("bp_res1", resp_result, 1);
    tick(); req_valid = 2'b00;
    #1 chk("bp_res2", resp_result, 2);
    chk("bp_alu_op3", alu_opd1, 3);
    tick();
    #1 chk("bp_res3", resp_result, 3);
    chk("bp_rv3", {30'b0, resp_valid}, 2'b01);
    tick(); tick();

    // reset while both stages hold work
    resp_ready = 2'b00;
    set_req(0, OPD12, ADDER, 3'b000, 40, 2, 0, 0);
    req_valid = 2'b01;
    tick(); tick(); req_valid = 2'b00;
    #1 chk("rmid_busy_before", {31'b0, busy}, 1);
    rst = 1; req_valid = 2'b11;
    #1 chk("rmid_resp_valid", {30'b0, resp_valid}, 0);
    chk("rmid_req_ready", {30'b0, req_ready}, 0);
    chk("rmid_busy", {31'b0, busy}, 0);
    tick(); tick();
    rst = 0;
    #1 chk("rmid_first_gnt", {30'b0, req_ready}, 2'b01);
    resp_ready = 2'b11;
    tick(); req_valid = 2'b00;
    repeat (3) tick();

    // random traffic, with the occasional reset
    for (int n = 0; n < 3000; n++) begin
      req_valid = 2'($urandom_range(0, 3));
      resp_ready = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      for (int i = 0; i < 2; i++)
        set_req(i, 1'($urandom), 2'($urandom), 3'($urandom),
                ($urandom_range(0, 1) != 0) ? $urandom : W'($urandom_range(0, 40)),
                ($urandom_range(0, 1) != 0) ? $urandom : W'($urandom_range(0, 40)),
                $urandom, $urandom);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0; req_valid = 2'b00; resp_ready = 2'b11;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
